mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences one shared 32-bit memory port between two requesters: A (load/store unit) and B (instruction fetch).
- Holds a grant for a whole transaction, which lasts from grant until memory ack or timeout.
- Drives o_sel, the select line of the 32-bit 2:1 select mux in front of the memory port. o_sel=1 selects A, o_sel=0 selects B.
- Sits between the pipeline's fetch/LSU stages and the single-ported memory.

Parameters:
- TIMEOUT, default 255: maximum cycles a grant waits for i_mem_ack. 0 disables the timeout.
- CNT_W, default 8: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-low reset.
- i_a_req  input  1  requester A wants a transaction; held high until o_a_ack or o_a_err.
- i_a_addr  input  32  A address; stable while i_a_req is high.
- i_a_wdata  input  32  A write data.
- i_a_we  input  1  A write enable.
- o_a_ack  output  1  one-cycle completion pulse to A.
- o_a_err  output  1  one-cycle timeout pulse to A.
- i_b_req, i_b_addr, i_b_wdata, i_b_we, o_b_ack, o_b_err: same as the A ports, for requester B.
- o_rdata  output  32  i_mem_rdata passed through; valid only when o_a_ack or o_b_ack is high.
- o_sel  output  1  mux select: 1=A, 0=B.
- o_mem_req  output  1  memory request strobe; high for every cycle of a grant.
- o_mem_addr  output  32  address of the granted requester.
- o_mem_wdata  output  32  write data of the granted requester.
- o_mem_we  output  1  write enable of the granted requester; gated by o_mem_req.
- i_mem_ack  input  1  memory completion; ignored when no grant is active.
- i_mem_rdata  input  32  memory read data.
- o_busy  output  1  high in either grant state.

Behaviour:
- FSM states: IDLE, GNT_A, GNT_B. The state is registered.
- Reset (i_reset=0 at a clock edge):
  - state returns to IDLE, the counter clears, last_grant is set to B.
  - All outputs become 0, including o_sel=0.
  - A reset mid-transaction aborts it silently: no ack, no err.
- IDLE:
  - o_mem_req=0.
  - If exactly one request is high, go to that grant state next cycle.
  - If both are high, arbitrate: fixed priority to A, or round-robin when ROUND_ROBIN_EN is defined.
  - Arbitration latency: req sampled at edge N, so o_mem_req=1 in cycle N+1.
- GNT_A / GNT_B:
  - o_sel = (state==GNT_A).
  - o_mem_addr, o_mem_wdata and o_mem_we come combinationally from the granted requester.
  - o_mem_req=1 and the counter increments each cycle.
- i_mem_ack=1 during a grant:
  - The granted o_x_ack=1 in the same cycle (combinational), with o_rdata=i_mem_rdata.
  - Next state is IDLE; the counter clears; last_grant records the served requester.
- Timeout, when TIMEOUT>0, counter==TIMEOUT-1 and no ack:
  - o_x_err=1 for that cycle; next state is IDLE; the counter clears.
  - Ack in the same cycle as timeout: ack wins, no err.
- Turnaround: at least one IDLE cycle between grants. Back-to-back requests complete at most once every 2 cycles with a 1-cycle memory.
- Requester drops its req mid-grant: protocol violation. The grant is held until ack or timeout, which are still signalled.
- The other requester's req during a grant is ignored until IDLE.
- o_x_ack and o_x_err are never high together. The two ack outputs are mutually exclusive, as are the two err outputs.
- o_rdata is zero when no ack is high.

Optional Feature:
- ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the requester not in last_grant. The first contention after reset goes to A.
- Not defined: A always wins contention, and last_grant is unused. B may starve while A requests continuously.

Test Plan:
- Reset: hold i_reset=0 with both reqs=1 for 3 cycles. Required: all outputs 0, state IDLE. Release reset: o_mem_req=1, o_sel=1 in the next cycle.
- Single B read: i_b_req=1, addr=0x0000_0100, memory acks 2 cycles after o_mem_req with rdata=0xDEAD_BEEF. Required: o_sel=0, o_mem_addr=0x100, o_b_ack pulses once with o_rdata=0xDEAD_BEEF, o_busy falls the next cycle.
- Contention, both reqs held, 1-cycle memory:
  - Without ROUND_ROBIN_EN: A is granted in every grant slot.
  - With ROUND_ROBIN_EN: grants alternate A,B,A,B over 8 transactions.
- Timeout: TIMEOUT=4, A req, no ack. Required: o_mem_req high exactly 4 cycles, o_a_err pulses in the 4th, then IDLE.
- Ack at the timeout boundary: ack arrives in cycle TIMEOUT-1. Required: o_a_ack=1, o_a_err=0.
- Mid-grant reset: i_reset=0 during GNT_A before ack. Required: IDLE next cycle, no ack/err, o_mem_req=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one shared 32-bit memory port; a grant lasts until memory ack or timeout.
// Define ROUND_ROBIN_EN for round-robin contention handling (default: A has fixed priority).
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_a_req,
    input  logic [31:0] i_a_addr,
    input  logic [31:0] i_a_wdata,
    input  logic        i_a_we,
    output logic        o_a_ack,
    output logic        o_a_err,
    input  logic        i_b_req,
    input  logic [31:0] i_b_addr,
    input  logic [31:0] i_b_wdata,
    input  logic        i_b_we,
    output logic        o_b_ack,
    output logic        o_b_err,
    output logic [31:0] o_rdata,
    output logic        o_sel,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_we,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    // Last counter value of a grant before it times out; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick_a;
    logic             grant_a, grant_b, granted;
    logic             timeout_hit;

`ifdef ROUND_ROBIN_EN
    // last_grant_q: 1 = A was served last, 0 = B (reset value, so A wins first contention).
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (granted && i_mem_ack) begin
            last_grant_d = grant_a;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign pick_a = ~last_grant_q;
`else
    assign pick_a = 1'b1;
`endif

    assign grant_a     = (state_q == GNT_A);
    assign grant_b     = (state_q == GNT_B);
    assign granted     = grant_a | grant_b;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_a_req && i_b_req) begin
                    state_d = pick_a ? GNT_A : GNT_B;
                end else if (i_a_req) begin
                    state_d = GNT_A;
                end else if (i_b_req) begin
                    state_d = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (i_mem_ack || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Ack beats a timeout landing in the same cycle.
    always_comb begin
        o_a_ack     = grant_a & i_mem_ack;
        o_b_ack     = grant_b & i_mem_ack;
        o_a_err     = grant_a & ~i_mem_ack & timeout_hit;
        o_b_err     = grant_b & ~i_mem_ack & timeout_hit;
        o_rdata     = (o_a_ack | o_b_ack) ? i_mem_rdata : '0;
        o_sel       = grant_a;
        o_mem_req   = granted;
        o_busy      = granted;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        if (grant_a) begin
            o_mem_addr  = i_a_addr;
            o_mem_wdata = i_a_wdata;
            o_mem_we    = i_a_we;
        end else if (grant_b) begin
            o_mem_addr  = i_b_addr;
            o_mem_wdata = i_b_wdata;
            o_mem_we    = i_b_we;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter built with TIMEOUT=4.
// Contention expectations follow ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_port_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_a_req, i_a_we, i_b_req, i_b_we;
    logic [31:0] i_a_addr, i_a_wdata, i_b_addr, i_b_wdata;
    logic        o_a_ack, o_a_err, o_b_ack, o_b_err;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic        o_sel, o_mem_req, o_mem_we, o_busy;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_a_req     (i_a_req),
        .i_a_addr    (i_a_addr),
        .i_a_wdata   (i_a_wdata),
        .i_a_we      (i_a_we),
        .o_a_ack     (o_a_ack),
        .o_a_err     (o_a_err),
        .i_b_req     (i_b_req),
        .i_b_addr    (i_b_addr),
        .i_b_wdata   (i_b_wdata),
        .i_b_we      (i_b_we),
        .o_b_ack     (o_b_ack),
        .o_b_err     (o_b_err),
        .o_rdata     (o_rdata),
        .o_sel       (o_sel),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_busy      (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Bundles the handshake outputs: {a_ack, a_err, b_ack, b_err, busy, mem_req, sel}.
    function automatic logic [31:0] hs();
        return {25'd0, o_a_ack, o_a_err, o_b_ack, o_b_err, o_busy, o_mem_req, o_sel};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_a;
        i_reset     = 1'b0;
        i_a_req     = 1'b1;
        i_b_req     = 1'b1;
        i_a_addr    = 32'h0000_0010;
        i_a_wdata   = 32'h1111_2222;
        i_a_we      = 1'b0;
        i_b_addr    = 32'h0000_0100;
        i_b_wdata   = 32'h3333_4444;
        i_b_we      = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h5555_AAAA;

        // Reset held with both requests asserted.
        repeat (3) tick();
        check("rst_hs", hs(), 32'h0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        i_reset = 1'b1;
        tick();
        check("post_rst_hs", hs(), 32'b0000111);
        check("post_rst_addr", o_mem_addr, 32'h0000_0010);
        i_mem_rdata = 32'h0000_1234;
        i_mem_ack   = 1'b1;
        #1;
        check("a_ack_hs", hs(), 32'b1000111);
        check("a_ack_rdata", o_rdata, 32'h0000_1234);
        i_a_req = 1'b0;
        i_b_req = 1'b0;
        tick();
        i_mem_ack = 1'b0;
        #1;
        check("a_done_hs", hs(), 32'h0);

        // Single B read, memory acks two cycles after the request strobe rises.
        i_b_req = 1'b1;
        tick();
        check("b_gnt_hs", hs(), 32'b0000110);
        check("b_addr", o_mem_addr, 32'h0000_0100);
        check("b_rdata_idle", o_rdata, 32'h0);
        repeat (2) tick();
        check("b_wait_hs", hs(), 32'b0000110);
        i_mem_rdata = 32'hDEAD_BEEF;
        i_mem_ack   = 1'b1;
        #1;
        check("b_ack_hs", hs(), 32'b0010110);
        check("b_ack_rdata", o_rdata, 32'hDEAD_BEEF);
        i_b_req = 1'b0;
        tick();
        check("b_idle_ack_ignored", hs(), 32'h0);
        check("b_idle_rdata", o_rdata, 32'h0);
        i_mem_ack = 1'b0;

        // Contention with a one-cycle memory; the last served requester was B.
        i_a_req = 1'b1;
        i_b_req = 1'b1;
        i_a_we  = 1'b1;
        #1;
        check("idle_we_gated", {31'd0, o_mem_we}, 32'h0);
        for (int i = 0; i < 8; i++) begin
`ifdef ROUND_ROBIN_EN
            exp_a = (i % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            tick();
            check($sformatf("cont%0d_sel", i), {31'd0, o_sel}, {31'd0, exp_a});
            check($sformatf("cont%0d_we", i), {31'd0, o_mem_we}, {31'd0, exp_a});
            i_mem_ack = 1'b1;
            #1;
            check($sformatf("cont%0d_ack", i), {30'd0, o_a_ack, o_b_ack}, {30'd0, exp_a, ~exp_a});
            tick();
            i_mem_ack = 1'b0;
            check($sformatf("cont%0d_idle", i), {31'd0, o_busy}, 32'h0);
        end
        i_a_req = 1'b0;
        i_b_req = 1'b0;
        tick();

        // Timeout with no ack: four request cycles, error on the fourth.
        i_a_req   = 1'b1;
        i_a_wdata = 32'h0000_CAFE;
        tick();
        check("to_wdata", o_mem_wdata, 32'h0000_CAFE);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("to_cyc%0d", k), hs(), (k == 4) ? 32'b0100111 : 32'b0000111);
            if (k == 4) i_a_req = 1'b0;
            tick();
        end
        check("to_idle", hs(), 32'h0);

        // Ack landing in the timeout cycle wins.
        i_a_req = 1'b1;
        i_a_we  = 1'b0;
        repeat (4) tick();
        i_mem_ack = 1'b1;
        #1;
        check("to_edge_ack", hs(), 32'b1000111);
        i_a_req = 1'b0;
        tick();
        i_mem_ack = 1'b0;
        check("to_edge_idle", hs(), 32'h0);

        // Reset during a grant aborts it silently.
        i_a_req = 1'b1;
        repeat (2) tick();
        check("mid_gnt_hs", hs(), 32'b0000111);
        i_reset = 1'b0;
        tick();
        check("mid_rst_hs", hs(), 32'h0);
        i_a_req = 1'b0;
        i_reset = 1'b1;
        tick();
        check("mid_rst_after", hs(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
